toeplitz_stream_hash: RTL and testbench
=======================================

TOEPLITZ_STREAM_HASH -- requirements
Module: toeplitz_stream_hash

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: message bits accepted per input beat (W).
REQ-002 SHALL have parameter TAG_WIDTH, default 40: hash tag width (T).
REQ-003 SHALL have parameter MAX_CHUNKS, default 6: maximum beats per message (C); message capacity is W*C bits.
REQ-004 SHALL have derived localparam KEY_WIDTH = W*C + T - 1.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 ss_tdata  input  W  message chunk; bit j of beat k is message bit k*W+j.
REQ-008 ss_tvalid  input  1  chunk valid.
REQ-009 ss_tlast  input  1  marks final chunk of a message.
REQ-010 ss_tready  output  1  chunk accept.
REQ-011 toeplitz_key  input  KEY_WIDTH  Toeplitz diagonal key; held stable by source for a whole message.
REQ-012 sm_tdata  output  T  tag.
REQ-013 sm_tuser  output  1  overflow flag; 1 = message exceeded C beats.
REQ-014 sm_tvalid  output  1  tag valid.
REQ-015 sm_tready  input  1  tag accept.

Function
REQ-016 Tag SHALL equal, for each r in 0..T-1, tag[r] = XOR over all accepted message bits i of (m[i] AND toeplitz_key[i+r]); bits beyond the last beat are treated as 0.
REQ-017 Beat transfer SHALL occur on a rising edge with ss_tvalid=1 and ss_tready=1; ss_tready SHALL be 1 in state ACCUM and 0 in state HOLD, combinationally from state only.
REQ-018 On each transfer in ACCUM with beat counter cnt < C: accumulator SHALL be XORed with the partial tag of the chunk using key offset cnt*W, and cnt SHALL increment.
REQ-019 On a transfer with cnt = C (overflow): chunk data SHALL be ignored, cnt SHALL hold at C, sticky overflow flag SHALL be set.
REQ-020 On a transfer with ss_tlast=1: sm_tdata SHALL register the final accumulator value including that beat, sm_tuser SHALL register the overflow flag including that beat, sm_tvalid SHALL go 1 on that same edge, state SHALL go to HOLD.
REQ-021 Latency SHALL be one edge: the tag is visible in the cycle after the tlast beat is accepted.
REQ-022 In HOLD, sm_tdata, sm_tuser and sm_tvalid SHALL stay constant until an edge with sm_tready=1.
REQ-023 On the edge with sm_tvalid=1 and sm_tready=1: sm_tvalid SHALL clear; accumulator, cnt and overflow flag SHALL clear; state SHALL go to ACCUM. No input beat SHALL be accepted on that edge.
REQ-024 A one-beat message (tlast on first beat) SHALL be supported; back-to-back messages SHALL achieve one tag per (beats+1) cycles with sm_tready held 1.
REQ-025 ss_tvalid low in ACCUM SHALL leave all state unchanged; sm_tdata contents SHALL be don't-care-stable (unchanged) while sm_tvalid=0.

Reset
REQ-026 While rst_n=0: state=ACCUM, accumulator=0, cnt=0, overflow=0, sm_tdata=0, sm_tuser=0, sm_tvalid=0; ss_tready=1 after deassertion.
REQ-027 Reset asserted mid-message or in HOLD SHALL discard the partial message and pending tag; no tag SHALL be emitted for it.

Verification (W=4, T=3, C=2, KEY_WIDTH=10, key=10'h2A5)
REQ-028 One beat 4'b0001 with tlast -> next cycle sm_tvalid=1, sm_tdata=3'b101, sm_tuser=0.
REQ-029 Beats 4'b0000 then 4'b0001 (tlast) -> sm_tdata=3'b010; beats 4'b0001 then 4'b0001 (tlast) -> sm_tdata=3'b111.
REQ-030 Tag pending with sm_tready=0 for 3 cycles and ss_tvalid=1 -> ss_tready=0, sm_tdata stable at 3'b101 for all 3 cycles; sm_tready=1 -> sm_tvalid=0 and ss_tready=1 next cycle.
REQ-031 Three beats 4'b0001, 4'b0000, 4'b1111 (tlast) -> sm_tdata=3'b101 (third beat ignored), sm_tuser=1; next message one beat 4'b0001 -> sm_tuser=0.
REQ-032 rst_n pulsed low after first beat 4'b0001, then one beat 4'b0000 with tlast -> sm_tdata=3'b000, sm_tuser=0.
REQ-033 Random regression: random W/T/C parameter sets, random message lengths 1..C+2, random valid/ready gaps -> tags match bit-level reference model of REQ-016/REQ-019.

Source files
------------

// File: rtl/toeplitz_stream_hash.sv
// Streaming Toeplitz hash: folds W-bit message beats into a T-bit tag with a
// diagonal key, then holds the tag on a registered output until it is taken.
module toeplitz_stream_hash #(
  parameter  int DATA_WIDTH = 32,
  parameter  int TAG_WIDTH  = 40,
  parameter  int MAX_CHUNKS = 6,
  localparam int KEY_WIDTH  = DATA_WIDTH * MAX_CHUNKS + TAG_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ss_tdata,
  input  logic                  ss_tvalid,
  input  logic                  ss_tlast,
  output logic                  ss_tready,
  input  logic [KEY_WIDTH-1:0]  toeplitz_key,
  output logic [TAG_WIDTH-1:0]  sm_tdata,
  output logic                  sm_tuser,
  output logic                  sm_tvalid,
  input  logic                  sm_tready
);

  // Handshakes: a beat or tag moves on a rising edge where valid and ready are
  // both 1; valid never depends on ready, and ss_tready is a decode of state.
  localparam int CNT_W = $clog2(MAX_CHUNKS + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                 r_state;
  logic [TAG_WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_ovf;

  logic [KEY_WIDTH-1:0]   w_key_shift;
  logic [TAG_WIDTH-1:0]   w_part;
  logic [TAG_WIDTH-1:0]   w_acc_next;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_at_cap;
  logic                   w_ovf_next;

  assign ss_tready = (r_state == ACCUM);

  // Partial tag of the current beat: the key window starts at bit cnt*W.
  always_comb begin
    w_key_shift = toeplitz_key >> (int'(r_cnt) * DATA_WIDTH);
    w_part      = '0;
    for (int r = 0; r < TAG_WIDTH; r++) begin
      for (int j = 0; j < DATA_WIDTH; j++) begin
        w_part[r] = w_part[r] ^ (ss_tdata[j] & w_key_shift[j + r]);
      end
    end
    w_at_cap   = (r_cnt == CNT_W'(MAX_CHUNKS));
    w_acc_next = w_at_cap ? r_acc : (r_acc ^ w_part);
    w_cnt_next = w_at_cap ? r_cnt : (r_cnt + CNT_W'(1));
    w_ovf_next = r_ovf | w_at_cap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ACCUM;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      sm_tdata  <= '0;
      sm_tuser  <= 1'b0;
      sm_tvalid <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (ss_tvalid) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            r_ovf <= w_ovf_next;
            if (ss_tlast) begin
              sm_tdata  <= w_acc_next;
              sm_tuser  <= w_ovf_next;
              sm_tvalid <= 1'b1;
              r_state   <= HOLD;
            end
          end
        end
        HOLD: begin
          // The release edge only clears; the next beat waits for ACCUM.
          if (sm_tready) begin
            sm_tvalid <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_state   <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_toeplitz_stream_hash.sv
// Directed bench for toeplitz_stream_hash at W=4, T=3, C=2 with key 10'h2A5,
// plus a model-checked random message run.
module tb_toeplitz_stream_hash;

  localparam int W  = 4;
  localparam int T  = 3;
  localparam int C  = 2;
  localparam int KW = W * C + T - 1;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  ss_tdata;
  logic          ss_tvalid;
  logic          ss_tlast;
  logic          ss_tready;
  logic [KW-1:0] toeplitz_key;
  logic [T-1:0]  sm_tdata;
  logic          sm_tuser;
  logic          sm_tvalid;
  logic          sm_tready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [T:0] exp_q[$];

  toeplitz_stream_hash #(
    .DATA_WIDTH(W),
    .TAG_WIDTH (T),
    .MAX_CHUNKS(C)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ss_tdata    (ss_tdata),
    .ss_tvalid   (ss_tvalid),
    .ss_tlast    (ss_tlast),
    .ss_tready   (ss_tready),
    .toeplitz_key(toeplitz_key),
    .sm_tdata    (sm_tdata),
    .sm_tuser    (sm_tuser),
    .sm_tvalid   (sm_tvalid),
    .sm_tready   (sm_tready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Bit-level Toeplitz tag over the first C beats; later beats only set overflow.
  function automatic logic [T:0] ref_tag(input logic [4*W-1:0] msg, input int nbeats);
    logic [T-1:0] tag;
    int nbits;
    tag   = '0;
    nbits = ((nbeats < C) ? nbeats : C) * W;
    for (int r = 0; r < T; r++)
      for (int i = 0; i < nbits; i++)
        tag[r] = tag[r] ^ (msg[i] & toeplitz_key[i + r]);
    return {(nbeats > C), tag};
  endfunction

  // ---------------- driver tasks (enter and leave at a negedge) ----------------
  task automatic send_beat(input logic [W-1:0] d, input logic l, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    ss_tdata  = d;
    ss_tlast  = l;
    ss_tvalid = 1'b1;
    n = 0;
    while (!ss_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ss_tready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_beat_timeout: ss_tready=%b after %0d cycles, required 1", ss_tready, n);
    end
    @(negedge clk);
    ss_tvalid = 1'b0;
    ss_tlast  = 1'b0;
  endtask

  task automatic get_tag(output logic [T-1:0] tag, output logic user, input int delay);
    int n;
    n = 0;
    while (!sm_tvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sm_tvalid) begin
      n_tests++;
      n_fail++;
      $display("FAIL get_tag_timeout: sm_tvalid=%b after %0d cycles, required 1", sm_tvalid, n);
    end
    tag  = sm_tdata;
    user = sm_tuser;
    repeat (delay) @(negedge clk);
    sm_tready = 1'b1;
    @(negedge clk);
    sm_tready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (sm_tvalid !== 1'b0 || sm_tdata !== 3'b000 || sm_tuser !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b data=%b user=%b, required 0 000 0",
               sm_tvalid, sm_tdata, sm_tuser);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ss_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tready: ss_tready=%b, required 1", ss_tready);
    end
    n_tests++;
    if (sm_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tvalid_after: sm_tvalid=%b, required 0", sm_tvalid);
    end
  endtask

  task automatic test_one_beat();
    send_beat(4'b0001, 1'b1, 0);
    n_tests++;
    if (sm_tvalid !== 1'b1 || sm_tdata !== 3'b101 || sm_tuser !== 1'b0) begin
      n_fail++;
      $display("FAIL one_beat: valid=%b data=%b user=%b, required 1 101 0",
               sm_tvalid, sm_tdata, sm_tuser);
    end
    sm_tready = 1'b1;
    @(negedge clk);
    sm_tready = 1'b0;
    n_tests++;
    if (sm_tvalid !== 1'b0 || ss_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL one_beat_release: valid=%b ss_tready=%b, required 0 1", sm_tvalid, ss_tready);
    end
  endtask

  task automatic test_two_beat();
    logic [T-1:0] tag;
    logic user;
    send_beat(4'b0000, 1'b0, 0);
    send_beat(4'b0001, 1'b1, 0);
    get_tag(tag, user, 0);
    n_tests++;
    if (tag !== 3'b010 || user !== 1'b0) begin
      n_fail++;
      $display("FAIL two_beat_offset: data=%b user=%b, required 010 0", tag, user);
    end
    send_beat(4'b0001, 1'b0, 1);
    send_beat(4'b0001, 1'b1, 2);
    get_tag(tag, user, 1);
    n_tests++;
    if (tag !== 3'b111 || user !== 1'b0) begin
      n_fail++;
      $display("FAIL two_beat_xor: data=%b user=%b, required 111 0", tag, user);
    end
  endtask

  task automatic test_hold();
    logic [T-1:0] tag;
    logic user;
    send_beat(4'b0001, 1'b1, 0);
    ss_tdata  = 4'b1111;
    ss_tlast  = 1'b0;
    ss_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (ss_tready !== 1'b0 || sm_tvalid !== 1'b1 || sm_tdata !== 3'b101) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: ss_tready=%b valid=%b data=%b, required 0 1 101",
                 i, ss_tready, sm_tvalid, sm_tdata);
      end
      @(negedge clk);
    end
    sm_tready = 1'b1;
    ss_tvalid = 1'b0;
    @(negedge clk);
    sm_tready = 1'b0;
    n_tests++;
    if (sm_tvalid !== 1'b0 || ss_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: valid=%b ss_tready=%b, required 0 1", sm_tvalid, ss_tready);
    end
    // Nothing from the held-off beat may have leaked into the next message.
    send_beat(4'b0001, 1'b1, 0);
    get_tag(tag, user, 0);
    n_tests++;
    if (tag !== 3'b101 || user !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_no_leak: data=%b user=%b, required 101 0", tag, user);
    end
  endtask

  task automatic test_overflow();
    logic [T-1:0] tag;
    logic user;
    send_beat(4'b0001, 1'b0, 0);
    send_beat(4'b0000, 1'b0, 0);
    send_beat(4'b1111, 1'b1, 0);
    get_tag(tag, user, 2);
    n_tests++;
    if (tag !== 3'b101 || user !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: data=%b user=%b, required 101 1", tag, user);
    end
    send_beat(4'b0001, 1'b1, 0);
    get_tag(tag, user, 0);
    n_tests++;
    if (tag !== 3'b101 || user !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_cleared: data=%b user=%b, required 101 0", tag, user);
    end
  endtask

  task automatic test_reset_mid();
    logic [T-1:0] tag;
    logic user;
    send_beat(4'b0001, 1'b0, 0);
    pulse_reset();
    send_beat(4'b0000, 1'b1, 0);
    get_tag(tag, user, 0);
    n_tests++;
    if (tag !== 3'b000 || user !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_message: data=%b user=%b, required 000 0", tag, user);
    end
    send_beat(4'b0001, 1'b1, 0);
    pulse_reset();
    n_tests++;
    if (sm_tvalid !== 1'b0 || sm_tdata !== 3'b000 || ss_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_hold: valid=%b data=%b ss_tready=%b, required 0 000 1",
               sm_tvalid, sm_tdata, ss_tready);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] bb_d[4];
    logic [T-1:0] bb_e[4];
    bb_d = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    bb_e = '{3'b101, 3'b010, 3'b001, 3'b100};
    sm_tready = 1'b1;
    ss_tdata  = bb_d[0];
    ss_tlast  = 1'b1;
    ss_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (sm_tvalid !== 1'b1 || sm_tdata !== bb_e[i] || ss_tready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_tag%0d: valid=%b data=%b ss_tready=%b, required 1 %b 0",
                 i, sm_tvalid, sm_tdata, ss_tready, bb_e[i]);
      end
      if (i < 3) ss_tdata = bb_d[i + 1];
      else ss_tvalid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (sm_tvalid !== 1'b0 || ss_tready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_gap%0d: valid=%b ss_tready=%b, required 0 1", i, sm_tvalid, ss_tready);
      end
    end
    ss_tlast  = 1'b0;
    sm_tready = 1'b0;
  endtask

  task automatic test_random();
    logic [4*W-1:0] msg;
    logic [T-1:0]   tag;
    logic           user;
    logic [T:0]     exp;
    int             nb;
    for (int m = 0; m < 24; m++) begin
      nb  = $urandom_range(1, C + 2);
      msg = '0;
      for (int b = 0; b < nb; b++) msg[b*W +: W] = W'($urandom_range(0, 15));
      exp_q.push_back(ref_tag(msg, nb));
      for (int b = 0; b < nb; b++)
        send_beat(msg[b*W +: W], (b == nb - 1), $urandom_range(0, 2));
      get_tag(tag, user, $urandom_range(0, 3));
      exp = exp_q.pop_front();
      n_tests++;
      if ({user, tag} !== exp) begin
        n_fail++;
        $display("FAIL random_msg%0d: user=%b data=%b, required user=%b data=%b (beats=%0d msg=%h)",
                 m, user, tag, exp[T], exp[T-1:0], nb, msg);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    toeplitz_key = 10'h2A5;
    ss_tdata     = '0;
    ss_tvalid    = 1'b0;
    ss_tlast     = 1'b0;
    sm_tready    = 1'b0;
    rst_n        = 1'b0;
    test_reset();
    test_one_beat();
    test_two_beat();
    test_hold();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
